// File: rtl/muldiv_pkg.sv
// ============================================================================
// muldiv_pkg : shared types and constants for the iterative multiply/divide
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITER  = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_if.sv
// ============================================================================
// muldiv_if : EX/ID-side signals of the multiply/divide sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_if;
    import muldiv_pkg::*;

    logic            startEX;
    logic [1:0]      opEX;
    logic [XLEN-1:0] srcAEX;
    logic [XLEN-1:0] srcBEX;
    logic            readHiLoID;
    logic            muldivID;
    logic            stallMD;
    logic            busy;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output startEX, opEX, srcAEX, srcBEX, readHiLoID, muldivID,
        input  stallMD, busy, hi, lo
    );

    modport slave (
        input  startEX, opEX, srcAEX, srcBEX, readHiLoID, muldivID,
        output stallMD, busy, hi, lo
    );

endinterface

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// muldiv_datapath : 64-bit accumulator, shift-add / restoring shift-subtract
// step and final sign fix. Divide path present only with MULDIV_DIV_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_datapath
    import muldiv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_load,
    input  wire logic            i_step,
    input  wire logic            i_fix,
    input  wire logic            i_is_div,
    input  wire logic            i_signed,
    input  wire logic [XLEN-1:0] i_src_a,
    input  wire logic [XLEN-1:0] i_src_b,
    output logic                 o_wr,
    output logic [XLEN-1:0]      o_hi,
    output logic [XLEN-1:0]      o_lo
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic              r_neg_lo;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_nxt;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;

    // Multiplier is consumed from the LSB end while the product fills from the top.
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};
    assign w_prod    = r_neg_lo ? -r_acc : r_acc;
    assign o_wr      = i_fix;

`ifdef MULDIV_DIV_EN
    logic              r_neg_hi;
    logic              r_is_div;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_div_nxt;

    // Trial subtract on the shifted partial remainder; borrow means restore.
    assign w_diff    = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb};
    assign w_div_nxt = w_diff[XLEN] ? {r_acc[2*XLEN-2:XLEN-1], r_acc[XLEN-2:0], 1'b0}
                                    : {w_diff[XLEN-1:0],        r_acc[XLEN-2:0], 1'b1};
    assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;

    always_comb begin
        o_hi = w_prod[2*XLEN-1:XLEN];
        o_lo = w_prod[XLEN-1:0];
        if (r_is_div) begin
            o_hi = r_neg_hi ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
            o_lo = r_neg_lo ? -r_acc[XLEN-1:0]      : r_acc[XLEN-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_neg_hi <= 1'b0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_neg_hi <= i_signed & i_src_a[XLEN-1];
            r_is_div <= i_is_div;
        end
    end
`else
    logic w_unused_is_div;

    assign w_unused_is_div = i_is_div;
    assign w_acc_nxt       = w_mul_nxt;
    assign o_hi            = w_prod[2*XLEN-1:XLEN];
    assign o_lo            = w_prod[XLEN-1:0];
`endif

    // Zero divisor leaves the all-ones quotient unnegated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_lo <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{XLEN{1'b0}}, abs_val(i_src_a, i_signed)};
            r_opb    <= abs_val(i_src_b, i_signed);
            r_neg_lo <= i_signed & (i_src_a[XLEN-1] ^ i_src_b[XLEN-1]) & (|i_src_b);
        end else if (i_step) begin
            r_acc    <= w_acc_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// ============================================================================
// muldiv_ctrl : iterative mult/div sequencer owning HI/LO and the MD stall.
// Divide support is built only when MULDIV_DIV_EN is defined.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    muldiv_if.slave   bus
);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;

    logic              w_is_mul;
    logic              w_is_div;
    logic              w_signed;
    logic              w_op_ok;
    logic              w_accept;
    logic              w_dp_wr;
    logic [XLEN-1:0]   w_dp_hi;
    logic [XLEN-1:0]   w_dp_lo;

    assign w_is_mul = (bus.opEX == OP_MULTU) || (bus.opEX == OP_MULT);
    assign w_is_div = (bus.opEX == OP_DIVU)  || (bus.opEX == OP_DIV);
    assign w_signed = (bus.opEX == OP_MULT)  || (bus.opEX == OP_DIV);

`ifdef MULDIV_DIV_EN
    assign w_op_ok = w_is_mul | w_is_div;
`else
    assign w_op_ok = w_is_mul;
`endif

    assign w_accept = bus.startEX & w_op_ok & (r_state == IDLE);

    // Combinational on startEX so an ID consumer stalls in the issue cycle itself.
    assign bus.stallMD = (r_busy | (bus.startEX & w_op_ok)) & (bus.readHiLoID | bus.muldivID);
    assign bus.busy    = r_busy;
    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;

    muldiv_datapath u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_accept),
        .i_step   (r_state == RUN),
        .i_fix    (r_state == FIX),
        .i_is_div (w_is_div),
        .i_signed (w_signed),
        .i_src_a  (bus.srcAEX),
        .i_src_b  (bus.srcBEX),
        .o_wr     (w_dp_wr),
        .o_hi     (w_dp_hi),
        .o_lo     (w_dp_lo)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_cnt   <= CNT_W'(ITER - 1);
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                FIX: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_dp_wr) begin
                r_hi <= w_dp_hi;
                r_lo <= w_dp_lo;
            end
        end
    end

endmodule

`default_nettype wire
